ibex_ifetch_req_ctrl: RTL and testbench

//  Instruction-bus request generator upstream of the fetch FIFO.

---
 rtl/ibex_ifetch_req_ctrl.sv | 122 ++++++++++++
 tb/tb_ibex_ifetch_req_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ifetch_req_ctrl.sv
// Instruction-bus fetch request generator: issues word-aligned requests, tracks outstanding
// transactions, discards responses orphaned by a branch and pushes survivors into the fetch FIFO.
module ibex_ifetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                busy_o
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
    localparam int unsigned SUM_W = $clog2(2 * NUM_REQS + 1);

    logic             en_q;
    logic [29:0]      fetch_addr_q, fetch_addr_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
    logic             hold_q, hold_d;

    logic [SUM_W-1:0] busy_cnt;
    logic             credit_ok;
    logic             branch;
    logic             req;
    logic             grant;
    logic             rvalid;
    logic             drop;
    logic [29:0]      addr_w;

    // Occupied FIFO entries plus in-flight responses must leave room for one more.
    always_comb begin
        busy_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            busy_cnt = busy_cnt + SUM_W'(fifo_busy_i[i]);
        end
    end

    assign credit_ok = (busy_cnt + SUM_W'(out_cnt_q)) < SUM_W'(NUM_REQS);
    assign branch    = en_q & branch_i;
    assign req       = en_q & (hold_q | (req_i & credit_ok));
    assign addr_w    = branch ? addr_i[31:2] : fetch_addr_q;
    assign grant     = req & instr_gnt_i;
    assign rvalid    = en_q & instr_rvalid_i;
    assign drop      = (disc_cnt_q != '0) | branch;

    always_comb begin
        out_cnt_d    = out_cnt_q;
        disc_cnt_d   = disc_cnt_q;
        fetch_addr_d = fetch_addr_q;
        hold_d       = req & ~instr_gnt_i;

        if (grant && !rvalid) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!grant && rvalid && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end

        // A branch orphans every transaction already granted; a same-cycle grant is kept.
        if (branch) begin
            disc_cnt_d = (rvalid && (out_cnt_q != '0)) ? out_cnt_q - CNT_W'(1) : out_cnt_q;
        end else if (rvalid && (disc_cnt_q != '0)) begin
            disc_cnt_d = disc_cnt_q - CNT_W'(1);
        end

        if (grant) begin
            fetch_addr_d = addr_w + 30'd1;
        end else if (branch) begin
            fetch_addr_d = addr_i[31:2];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q         <= 1'b0;
            fetch_addr_q <= '0;
            out_cnt_q    <= '0;
            disc_cnt_q   <= '0;
            hold_q       <= 1'b0;
        end else begin
            en_q         <= 1'b1;
            fetch_addr_q <= fetch_addr_d;
            out_cnt_q    <= out_cnt_d;
            disc_cnt_q   <= disc_cnt_d;
            hold_q       <= hold_d;
        end
    end

    assign instr_req_o  = req;
    assign instr_addr_o = en_q ? {addr_w, 2'b00} : '0;
    assign fifo_clear_o = branch;
    assign fifo_addr_o  = branch ? addr_i : '0;
    assign fifo_valid_o = rvalid & ~drop;
    assign fifo_rdata_o = en_q ? instr_rdata_i : '0;
    assign fifo_err_o   = en_q & instr_err_i;
    assign busy_o       = en_q & ((out_cnt_q != '0) | hold_q);

    a_out_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
        out_cnt_q <= CNT_W'(NUM_REQS));
    a_disc_le_out: assert property (@(posedge clk_i) disable iff (rst_i)
        disc_cnt_q <= out_cnt_q);
    a_rvalid_owned: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid |-> (out_cnt_q != '0));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_valid_o && fifo_busy_i[NUM_REQS-1]));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (hold_q && !branch_i) |-> $stable(instr_addr_o));

endmodule

// File: tb/tb_ibex_ifetch_req_ctrl.sv
// Directed bench for ibex_ifetch_req_ctrl: inputs change 1ns after posedge, outputs sampled 2ns later.
module tb_ibex_ifetch_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic [1:0]  fifo_busy_i;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    ibex_ifetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic br, input logic [31:0] a,
                         input logic [1:0] fb, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic er);
        req_i          = req;
        branch_i       = br;
        addr_i         = a;
        fifo_busy_i    = fb;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        instr_err_i    = er;
        #2;
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        next_cyc();
        // Reset: everything gated low even with live inputs
        drive(1'b1, 1'b1, 32'h1234, 2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        chk("rst_req",    32'(instr_req_o), 32'd0);
        chk("rst_addr",   instr_addr_o, 32'h0);
        chk("rst_clear",  32'(fifo_clear_o), 32'd0);
        chk("rst_faddr",  fifo_addr_o, 32'h0);
        chk("rst_rdata",  fifo_rdata_o, 32'h0);
        chk("rst_err",    32'(fifo_err_o), 32'd0);
        chk("rst_busy",   32'(busy_o), 32'd0);
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("en_wait_req", 32'(instr_req_o), 32'd0);
        next_cyc();

        // 1: back-to-back grants then credit stall
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_req0",  32'(instr_req_o), 32'd1);
        chk("t1_addr0", instr_addr_o, 32'h0);
        chk("t1_nopush0", 32'(fifo_valid_o), 32'd0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'hA0, 1'b0);
        chk("t1_req1",   32'(instr_req_o), 32'd1);
        chk("t1_addr1",  instr_addr_o, 32'h4);
        chk("t1_push0",  32'(fifo_valid_o), 32'd1);
        chk("t1_rdata0", fifo_rdata_o, 32'hA0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1, 32'hA1, 1'b1);
        chk("t1_credit_stall", 32'(instr_req_o), 32'd0);
        chk("t1_push1",  32'(fifo_valid_o), 32'd1);
        chk("t1_rdata1", fifo_rdata_o, 32'hA1);
        chk("t1_err1",   32'(fifo_err_o), 32'd1);
        chk("t1_busy",   32'(busy_o), 32'd1);
        next_cyc();
        // 5: FIFO full blocks new requests
        drive(1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_full_noreq", 32'(instr_req_o), 32'd0);
        chk("t5_idle",   32'(busy_o), 32'd0);
        next_cyc();

        // 2: branch to 0x100 with grant held off; request held
        drive(1'b1, 1'b1, 32'h100, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_req_br",   32'(instr_req_o), 32'd1);
        chk("t2_addr_br",  instr_addr_o, 32'h100);
        chk("t2_clear",    32'(fifo_clear_o), 32'd1);
        chk("t2_faddr",    fifo_addr_o, 32'h100);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_hold_req",  32'(instr_req_o), 32'd1);
        chk("t2_hold_addr", instr_addr_o, 32'h100);
        chk("t2_hold_busy", 32'(busy_o), 32'd1);
        chk("t2_noclear",   32'(fifo_clear_o), 32'd0);
        chk("t2_faddr0",    fifo_addr_o, 32'h0);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_hold_req_full", 32'(instr_req_o), 32'd1);
        chk("t2_hold_addr2",    instr_addr_o, 32'h100);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_hold_gnt_req",  32'(instr_req_o), 32'd1);
        chk("t5_hold_gnt_addr", instr_addr_o, 32'h100);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_after_noreq", 32'(instr_req_o), 32'd0);
        chk("t5_after_busy",  32'(busy_o), 32'd1);
        next_cyc();

        // 3: second outstanding, then branch orphans both
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_req2",  32'(instr_req_o), 32'd1);
        chk("t3_addr2", instr_addr_o, 32'h104);
        next_cyc();
        drive(1'b1, 1'b1, 32'h2002, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_clear", 32'(fifo_clear_o), 32'd1);
        chk("t3_faddr", fifo_addr_o, 32'h2002);
        chk("t3_iaddr", instr_addr_o, 32'h2000);
        chk("t3_noreq", 32'(instr_req_o), 32'd0);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hB0, 1'b0);
        chk("t3_drop0", 32'(fifo_valid_o), 32'd0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'hB1, 1'b0);
        chk("t3_drop1", 32'(fifo_valid_o), 32'd0);
        chk("t3_req_new",  32'(instr_req_o), 32'd1);
        chk("t3_addr_new", instr_addr_o, 32'h2000);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hB2, 1'b0);
        chk("t3_push2",  32'(fifo_valid_o), 32'd1);
        chk("t3_rdata2", fifo_rdata_o, 32'hB2);
        next_cyc();

        // 4: branch + grant + rvalid together with one outstanding
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_addr_pre", instr_addr_o, 32'h2004);
        next_cyc();
        drive(1'b1, 1'b1, 32'h3000, 2'b00, 1'b1, 1'b1, 32'hBAD, 1'b0);
        chk("t4_req",   32'(instr_req_o), 32'd1);
        chk("t4_addr",  instr_addr_o, 32'h3000);
        chk("t4_drop",  32'(fifo_valid_o), 32'd0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hC0, 1'b0);
        chk("t4_out_cnt",  32'(dut.out_cnt_q), 32'd1);
        chk("t4_disc_cnt", 32'(dut.disc_cnt_q), 32'd0);
        chk("t4_next_addr", instr_addr_o, 32'h3004);
        chk("t4_push",  32'(fifo_valid_o), 32'd1);
        chk("t4_rdata", fifo_rdata_o, 32'hC0);
        next_cyc();

        // 6: reset with one outstanding and a held request
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_gnt_addr", instr_addr_o, 32'h3004);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_pre_req",  32'(instr_req_o), 32'd1);
        chk("t6_pre_addr", instr_addr_o, 32'h3008);
        next_cyc();
        chk("t6_pre_hold", 32'(dut.hold_q), 32'd1);
        chk("t6_pre_out",  32'(dut.out_cnt_q), 32'd1);
        rst_i = 1'b1;
        drive(1'b1, 1'b1, 32'h4000, 2'b00, 1'b1, 1'b0, 32'h55, 1'b1);
        chk("t6_req",   32'(instr_req_o), 32'd0);
        chk("t6_addr",  instr_addr_o, 32'h0);
        chk("t6_clear", 32'(fifo_clear_o), 32'd0);
        chk("t6_faddr", fifo_addr_o, 32'h0);
        chk("t6_rdata", fifo_rdata_o, 32'h0);
        chk("t6_busy",  32'(busy_o), 32'd0);
        chk("t6_out",   32'(dut.out_cnt_q), 32'd0);
        chk("t6_disc",  32'(dut.disc_cnt_q), 32'd0);
        chk("t6_hold",  32'(dut.hold_q), 32'd0);
        next_cyc();
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_en_wait", 32'(instr_req_o), 32'd0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_first_req",  32'(instr_req_o), 32'd1);
        chk("t6_first_addr", instr_addr_o, 32'h0);
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
